// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared VGA timing, packed polygon widths and commit FSM encoding
package gpu_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_TOTAL  = 525;

    localparam int COLOR_W  = 6;
    localparam int X_W      = 7;
    localparam int Y_W      = 6;
    localparam int NPOLY    = 2;
    localparam int PCOLOR_W = COLOR_W * NPOLY;
    localparam int VX_W     = X_W * NPOLY;
    localparam int VY_W     = Y_W * NPOLY;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COMMIT  = 2'd2
    } commit_state_t;

    // Field order matches the frontend's sh_* port order; dirty compares the whole word.
    typedef struct packed {
        logic [COLOR_W-1:0]  bg_color;
        logic [PCOLOR_W-1:0] poly_color;
        logic [VX_W-1:0]     v0_x;
        logic [VY_W-1:0]     v0_y;
        logic [VX_W-1:0]     v1_x;
        logic [VY_W-1:0]     v1_y;
        logic [VX_W-1:0]     v2_x;
        logic [VY_W-1:0]     v2_y;
        logic [NPOLY-1:0]    poly_en;
    } frame_t;

endpackage

// File: rtl/frame_commit_ctrl_if.sv
// rtl/frame_commit_ctrl_if.sv - shadow (frontend) and committed (rasterizer) polygon buses
interface frame_commit_ctrl_if;
    import gpu_pkg::*;

    logic [COLOR_W-1:0]  sh_bg_color,   act_bg_color;
    logic [PCOLOR_W-1:0] sh_poly_color, act_poly_color;
    logic [VX_W-1:0]     sh_v0_x,       act_v0_x;
    logic [VY_W-1:0]     sh_v0_y,       act_v0_y;
    logic [VX_W-1:0]     sh_v1_x,       act_v1_x;
    logic [VY_W-1:0]     sh_v1_y,       act_v1_y;
    logic [VX_W-1:0]     sh_v2_x,       act_v2_x;
    logic [VY_W-1:0]     sh_v2_y,       act_v2_y;
    logic [NPOLY-1:0]    sh_poly_en,    act_poly_en;

    modport master (
        output sh_bg_color, sh_poly_color, sh_v0_x, sh_v0_y, sh_v1_x, sh_v1_y,
               sh_v2_x, sh_v2_y, sh_poly_en,
        input  act_bg_color, act_poly_color, act_v0_x, act_v0_y, act_v1_x, act_v1_y,
               act_v2_x, act_v2_y, act_poly_en
    );

    modport slave (
        input  sh_bg_color, sh_poly_color, sh_v0_x, sh_v0_y, sh_v1_x, sh_v1_y,
               sh_v2_x, sh_v2_y, sh_poly_en,
        output act_bg_color, act_poly_color, act_v0_x, act_v0_y, act_v1_x, act_v1_y,
               act_v2_x, act_v2_y, act_poly_en
    );

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for an asynchronous single-bit input
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/frame_commit_ctrl.sv
// rtl/frame_commit_ctrl.sv - blanking-gated SPI load enable and tear-free polygon commit (stats: FRAME_COMMIT_STATS_EN)
module frame_commit_ctrl
    import gpu_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_TOTAL  = VGA_V_TOTAL
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           hpos,
    input  logic [9:0]           vpos,
    input  logic                 display_en,
    input  logic                 spi_cs_n,
    output logic                 en_load,
    output logic                 commit_pulse,
    output logic                 commit_pending,
`ifdef FRAME_COMMIT_STATS_EN
    output logic [3:0]           missed_cnt,
    output logic [7:0]           commit_cnt,
`endif
    frame_commit_ctrl_if.slave   fb
);

    localparam logic [9:0] HA = 10'(H_ACTIVE);
    localparam logic [9:0] HL = 10'(H_TOTAL - 1);
    localparam logic [9:0] VA = 10'(V_ACTIVE);
    localparam logic [9:0] VL = 10'(V_TOTAL - 1);

    logic          cs_s;
    logic          spi_idle;
    logic          load_hold;
    logic          blank;
    logic          vblank_start;
    logic          frame_end;
    logic          dirty;
    frame_t        sh_f;
    frame_t        act_q;
    commit_state_t state;

    sync2 #(.RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_cs_n),
        .q     (cs_s)
    );

    assign spi_idle     = cs_s;
    assign blank        = (hpos >= HA) | (vpos >= VA);
    assign vblank_start = (hpos == 10'd0) & (vpos == VA);
    assign frame_end    = (hpos == HL) & (vpos == VL);

    assign sh_f = {fb.sh_bg_color, fb.sh_poly_color, fb.sh_v0_x, fb.sh_v0_y,
                   fb.sh_v1_x, fb.sh_v1_y, fb.sh_v2_x, fb.sh_v2_y, fb.sh_poly_en};
    assign dirty = (sh_f != act_q);

    assign fb.act_bg_color   = act_q.bg_color;
    assign fb.act_poly_color = act_q.poly_color;
    assign fb.act_v0_x       = act_q.v0_x;
    assign fb.act_v0_y       = act_q.v0_y;
    assign fb.act_v1_x       = act_q.v1_x;
    assign fb.act_v1_y       = act_q.v1_y;
    assign fb.act_v2_x       = act_q.v2_x;
    assign fb.act_v2_y       = act_q.v2_y;
    assign fb.act_poly_en    = act_q.poly_en;

    // A transfer that began while loads were allowed keeps en_load up until CS releases.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_load   <= 1'b0;
            load_hold <= 1'b0;
        end else begin
            en_load <= ~display_en | blank | load_hold;
            if (cs_s)
                load_hold <= 1'b0;
            else if (en_load)
                load_hold <= 1'b1;
        end
    end

    // act_q is written on the PENDING->COMMIT edge, so the COMMIT cycle is the one
    // where the new values and commit_pulse are both visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            act_q          <= '0;
            commit_pulse   <= 1'b0;
            commit_pending <= 1'b0;
`ifdef FRAME_COMMIT_STATS_EN
            missed_cnt     <= 4'd0;
            commit_cnt     <= 8'd0;
`endif
        end else begin
            commit_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dirty && (!display_en || vblank_start)) begin
                        state          <= ST_PENDING;
                        commit_pending <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (spi_idle && !load_hold) begin
                        state          <= ST_COMMIT;
                        commit_pending <= 1'b0;
                        commit_pulse   <= 1'b1;
                        act_q          <= sh_f;
`ifdef FRAME_COMMIT_STATS_EN
                        commit_cnt     <= commit_cnt + 8'd1;
`endif
                    end else if (frame_end) begin
                        state          <= ST_IDLE;
                        commit_pending <= 1'b0;
`ifdef FRAME_COMMIT_STATS_EN
                        if (missed_cnt != 4'hf)
                            missed_cnt <= missed_cnt + 4'd1;
`endif
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state          <= ST_IDLE;
                    commit_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_commit_ctrl.sv
// tb/tb_frame_commit_ctrl.sv - self-checking bench for frame_commit_ctrl
module tb_frame_commit_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_en;
    logic       spi_cs_n;
    logic       en_load;
    logic       commit_pulse;
    logic       commit_pending;
`ifdef FRAME_COMMIT_STATS_EN
    logic [3:0] missed_cnt;
    logic [7:0] commit_cnt;
`endif

    frame_commit_ctrl_if bus ();

    frame_commit_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hpos           (hpos),
        .vpos           (vpos),
        .display_en     (display_en),
        .spi_cs_n       (spi_cs_n),
        .en_load        (en_load),
        .commit_pulse   (commit_pulse),
        .commit_pending (commit_pending),
`ifdef FRAME_COMMIT_STATS_EN
        .missed_cnt     (missed_cnt),
        .commit_cnt     (commit_cnt),
`endif
        .fb             (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int n_commits = 0;
    logic [97:0] sb_q[$];

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       de;
        logic       exp_en_load;
    } en_vec_t;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [97:0] sh_vec();
        return {bus.sh_bg_color, bus.sh_poly_color, bus.sh_v0_x, bus.sh_v0_y, bus.sh_v1_x,
                bus.sh_v1_y, bus.sh_v2_x, bus.sh_v2_y, bus.sh_poly_en};
    endfunction

    function automatic logic [97:0] act_vec();
        return {bus.act_bg_color, bus.act_poly_color, bus.act_v0_x, bus.act_v0_y, bus.act_v1_x,
                bus.act_v1_y, bus.act_v2_x, bus.act_v2_y, bus.act_poly_en};
    endfunction

    task automatic set_sh(input logic [97:0] f);
        {bus.sh_bg_color, bus.sh_poly_color, bus.sh_v0_x, bus.sh_v0_y, bus.sh_v1_x,
         bus.sh_v1_y, bus.sh_v2_x, bus.sh_v2_y, bus.sh_poly_en} = f;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_commit();
        sb_q.push_back(sh_vec());
        n_commits++;
    endtask

    task automatic wait_pulse(input string name, input int bound);
        int n = 0;
        while (!commit_pulse && n < bound) begin
            cyc();
            n++;
        end
        chk(name, {127'd0, commit_pulse}, 128'd1);
    endtask

    // Every commit_pulse must match the oldest expected frame, and none may be unexpected.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && commit_pulse === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_commit: got act %0h expected no commit", act_vec());
            end else begin
                chk("commit_act", act_vec(), sb_q.pop_front());
            end
        end
    end

    en_vec_t vecs[8];

    initial begin
        vecs[0] = '{10'd100, 10'd10,  1'b1, 1'b0};
        vecs[1] = '{10'd700, 10'd10,  1'b1, 1'b1};
        vecs[2] = '{10'd639, 10'd100, 1'b1, 1'b0};
        vecs[3] = '{10'd640, 10'd100, 1'b1, 1'b1};
        vecs[4] = '{10'd0,   10'd479, 1'b1, 1'b0};
        vecs[5] = '{10'd0,   10'd480, 1'b1, 1'b1};
        vecs[6] = '{10'd799, 10'd524, 1'b1, 1'b1};
        vecs[7] = '{10'd100, 10'd10,  1'b0, 1'b1};

        // Reset with nonzero shadows
        rst_n = 1'b0; hpos = 10'd100; vpos = 10'd10; display_en = 1'b1; spi_cs_n = 1'b1;
        set_sh({6'h3F, 12'hABC, 14'h1111, 12'h222, 14'h0333, 12'h444, 14'h0555, 12'h666, 2'b11});
        repeat (4) cyc();
        chk("rst_act", act_vec(), 128'd0);
        chk("rst_en_load", {127'd0, en_load}, 128'd0);
        chk("rst_pulse", {127'd0, commit_pulse}, 128'd0);
        chk("rst_pending", {127'd0, commit_pending}, 128'd0);
`ifdef FRAME_COMMIT_STATS_EN
        chk("rst_missed", {124'd0, missed_cnt}, 128'd0);
        chk("rst_ccnt", {120'd0, commit_cnt}, 128'd0);
`endif
        set_sh('0);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 8; i++) begin
            hpos = vecs[i].h; vpos = vecs[i].v; display_en = vecs[i].de;
            cyc();
            chk($sformatf("en_load_vec%0d", i), {127'd0, en_load}, {127'd0, vecs[i].exp_en_load});
        end
        display_en = 1'b1;

        // Shadow written in active video waits for vblank
        hpos = 10'd100; vpos = 10'd100;
        bus.sh_v0_x = 14'h0A05;
        repeat (5) cyc();
        chk("active_hold_v0x", {114'd0, bus.act_v0_x}, 128'd0);
        chk("active_no_pending", {127'd0, commit_pending}, 128'd0);
        hpos = 10'd0; vpos = 10'd480;
        expect_commit();
        cyc();
        hpos = 10'd1;
        chk("vb_pending", {127'd0, commit_pending}, 128'd1);
        chk("vb_no_pulse_yet", {127'd0, commit_pulse}, 128'd0);
        cyc();
        chk("vb_pulse_t2", {127'd0, commit_pulse}, 128'd1);
        chk("vb_v0x", {114'd0, bus.act_v0_x}, {114'd0, 14'h0A05});
        cyc();

        // en_load held open by a transfer spanning the end of blanking
        hpos = 10'd650; vpos = 10'd10; spi_cs_n = 1'b0;
        for (int h = 650; h < 800; h++) begin hpos = 10'(h); cyc(); end
        vpos = 10'd11;
        for (int h = 0; h < 20; h++) begin hpos = 10'(h); cyc(); end
        chk("hold_mid_active", {127'd0, en_load}, 128'd1);
        begin
            int n;
            n = 0;
            hpos = 10'd20; spi_cs_n = 1'b1;
            while (en_load && n < 10) begin cyc(); n++; hpos = hpos + 10'd1; end
            chk("hold_release_cycles", 128'(n), 128'd4);
        end

        // CS held low through vblank: commit missed at frame_end
        bus.sh_v1_y = 12'h5A5;
        hpos = 10'd700; vpos = 10'd478; spi_cs_n = 1'b0;
        repeat (4) cyc();
        hpos = 10'd0; vpos = 10'd480;
        cyc();
        hpos = 10'd1;
        repeat (8) cyc();
        chk("miss_pending", {127'd0, commit_pending}, 128'd1);
        hpos = 10'd799; vpos = 10'd524;
        cyc();
        hpos = 10'd0; vpos = 10'd0;
        chk("miss_idle", {127'd0, commit_pending}, 128'd0);
`ifdef FRAME_COMMIT_STATS_EN
        chk("miss_cnt", {124'd0, missed_cnt}, 128'd1);
`endif
        hpos = 10'd100; vpos = 10'd5;
        repeat (3) cyc();
        chk("miss_no_repend", {127'd0, commit_pending}, 128'd0);
        hpos = 10'd0; vpos = 10'd480; spi_cs_n = 1'b1;
        expect_commit();
        cyc();
        hpos = 10'd1;
        wait_pulse("retry_commit", 10);
        chk("retry_v1y", {116'd0, bus.act_v1_y}, {116'd0, 12'h5A5});
        cyc();

        // frame_end coinciding with a ready PENDING: commit wins
        bus.sh_v2_y = 12'h0F0;
        hpos = 10'd0; vpos = 10'd480;
        expect_commit();
        cyc();
        hpos = 10'd799; vpos = 10'd524;
        cyc();
        chk("fe_commit_wins", {127'd0, commit_pulse}, 128'd1);
        hpos = 10'd0; vpos = 10'd0;
        cyc();

        // display_en falling while PENDING keeps the commit pending
        bus.sh_v2_x = 14'h1234;
        hpos = 10'd700; vpos = 10'd478; spi_cs_n = 1'b0;
        repeat (3) cyc();
        hpos = 10'd0; vpos = 10'd480;
        cyc();
        hpos = 10'd1; display_en = 1'b0;
        repeat (3) cyc();
        chk("de_fall_pending", {127'd0, commit_pending}, 128'd1);
        spi_cs_n = 1'b1;
        expect_commit();
        wait_pulse("de_fall_commit", 10);
        display_en = 1'b1;
        repeat (2) cyc();

        // Display off: commit anywhere, en_load always up
        display_en = 1'b0; hpos = 10'd100; vpos = 10'd100;
        bus.sh_bg_color = 6'h2A;
        expect_commit();
        wait_pulse("doff_commit", 3);
        chk("doff_bg", {122'd0, bus.act_bg_color}, {122'd0, 6'h2A});
        chk("doff_en_load", {127'd0, en_load}, 128'd1);
        display_en = 1'b1;
        repeat (2) cyc();

        // Clean shadows at vblank_start: nothing to do
        hpos = 10'd0; vpos = 10'd480;
        cyc();
        hpos = 10'd1;
        chk("clean_no_pending", {127'd0, commit_pending}, 128'd0);
        repeat (3) cyc();

`ifdef FRAME_COMMIT_STATS_EN
        chk("commit_cnt", {120'd0, commit_cnt}, 128'(n_commits));
`endif

        // Reset mid-PENDING drops everything
        bus.sh_poly_en = 2'b10; spi_cs_n = 1'b0;
        hpos = 10'd700; vpos = 10'd478;
        repeat (3) cyc();
        hpos = 10'd0; vpos = 10'd480;
        cyc();
        chk("rstmid_pending", {127'd0, commit_pending}, 128'd1);
        rst_n = 1'b0;
        cyc();
        chk("rstmid_act", act_vec(), 128'd0);
        chk("rstmid_pending_clr", {127'd0, commit_pending}, 128'd0);
        rst_n = 1'b1; spi_cs_n = 1'b1; set_sh('0);
        repeat (3) cyc();

        chk("sb_drained", 128'(sb_q.size()), 128'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
